// File: rtl/moore_bit_serializer.sv
// Moore-style parallel-to-serial converter with downstream stall (hold) and zero-gap back-to-back words.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module moore_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             hold,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             x_n, x_valid_n, busy_n;
  logic             load, finish;
`ifdef SERIALIZER_PARITY_EN
  logic             par, par_n;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // The acceptance slot is the last presented bit of a word, so a new word follows with no gap.
`ifdef SERIALIZER_PARITY_EN
  assign din_ready = rst && ((state == IDLE) || (!hold && (state == PAR)));
`else
  assign din_ready = rst && ((state == IDLE) || (!hold && (state == SHIFT) && (cnt == LAST)));
`endif

  assign load = din_valid && din_ready;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sreg_n    = sreg;
    x_n       = x;
    x_valid_n = 1'b0;
    busy_n    = busy;
    finish    = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_n     = par;
`endif
    unique case (state)
      IDLE: ;
      SHIFT: begin
        if (!hold) begin
          if (cnt != LAST) begin
            cnt_n     = cnt + CW'(1);
            x_n       = first_bit(sreg);
            sreg_n    = advance(sreg);
            x_valid_n = 1'b1;
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state_n   = PAR;
            x_n       = par;
            x_valid_n = 1'b1;
`else
            finish    = !load;
`endif
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PAR: finish = !hold && !load;
`endif
      default: ;
    endcase

    // A transfer always restarts the word, whichever state accepted it.
    if (load) begin
      state_n   = SHIFT;
      cnt_n     = '0;
      x_n       = first_bit(din);
      sreg_n    = advance(din);
      x_valid_n = 1'b1;
      busy_n    = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      par_n     = ^din;
`endif
    end else if (finish) begin
      state_n   = IDLE;
      cnt_n     = '0;
      sreg_n    = '0;
      x_n       = 1'b0;
      busy_n    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sreg    <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sreg    <= sreg_n;
      x       <= x_n;
      x_valid <= x_valid_n;
      busy    <= busy_n;
`ifdef SERIALIZER_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_moore_bit_serializer.sv
// Scoreboard bench: MSB-first and LSB-first serializers share one stimulus stream; a word-level model
// queues the expected bits and a negedge monitor pops them as the DUTs present x_valid.
module tb_moore_bit_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, din_valid, hold;
  logic [WIDTH-1:0] din;
  logic             x_m, xv_m, busy_m, rdy_m;
  logic             x_l, xv_l, busy_l, rdy_l;

  moore_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .hold(hold), .x(x_m), .x_valid(xv_m), .busy(busy_m));

  moore_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .hold(hold), .x(x_l), .x_valid(xv_l), .busy(busy_l));

  always #5 clk = ~clk;

  int   compared = 0, mismatched = 0;
  bit   q_m[$], q_l[$];
  logic exp_xv = 1'b0, exp_busy = 1'b0, exp_x0 = 1'b0;
  logic last_m = 1'b0, last_l = 1'b0;
  bit   unretired = 0, started = 0, xfer = 0;
  int   shown_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) begin
      q_m.push_back(w[WIDTH-1-i]);
      q_l.push_back(w[i]);
    end
`ifdef SERIALIZER_PARITY_EN
    q_m.push_back(^w);
    q_l.push_back(^w);
`endif
  endfunction

  // Monitor + reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic exp_rdy;
    if (started) begin
      check("x_valid_msb", 32'(xv_m), 32'(exp_xv));
      check("x_valid_lsb", 32'(xv_l), 32'(exp_xv));
      check("busy_msb", 32'(busy_m), 32'(exp_busy));
      check("busy_lsb", 32'(busy_l), 32'(exp_busy));
      if (exp_x0) check("x_after_reset", 32'({x_m, x_l}), 32'(0));
    end
    if (xv_m === 1'b1) begin
      if (q_m.size() == 0) check("x_msb_unexpected", 32'(xv_m), 32'(0));
      else check("x_msb_bit", 32'(x_m), 32'(q_m.pop_front()));
      last_m = x_m;
      unretired = 1;
      shown_cnt++;
    end else if (started && exp_busy) begin
      check("x_msb_frozen", 32'(x_m), 32'(last_m));
    end
    if (xv_l === 1'b1) begin
      if (q_l.size() == 0) check("x_lsb_unexpected", 32'(xv_l), 32'(0));
      else check("x_lsb_bit", 32'(x_l), 32'(q_l.pop_front()));
      last_l = x_l;
    end else if (started && exp_busy) begin
      check("x_lsb_frozen", 32'(x_l), 32'(last_l));
    end
    exp_rdy = rst && (!exp_busy || (!hold && q_m.size() == 0 && unretired));
    if (started) begin
      check("din_ready_msb", 32'(rdy_m), 32'(exp_rdy));
      check("din_ready_lsb", 32'(rdy_l), 32'(exp_rdy));
    end
    xfer = din_valid && exp_rdy;
    if (!rst) begin
      q_m.delete();
      q_l.delete();
      unretired = 0;
      exp_xv    = 1'b0;
      exp_busy  = 1'b0;
      exp_x0    = 1'b1;
    end else begin
      exp_xv   = xfer || (q_m.size() > 0 && !hold);
      exp_busy = xfer || (q_m.size() > 0) || (unretired && hold);
      exp_x0   = 1'b0;
      if (!hold) unretired = 0;
      if (xfer) push_word(din);
    end
    started = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    bit ok = 0;
    din = w;
    din_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (xfer) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", 32'(ok), 32'(1));
    #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (!exp_busy && q_m.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", 32'(ok), 32'(1));
    tick();
  endtask

  task automatic wait_shown(input int target);
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (shown_cnt >= target) begin ok = 1; break; end
      tick();
    end
    if (!ok) check("shown_timeout", 32'(ok), 32'(1));
  endtask

  initial begin
    rst = 1'b0; din_valid = 1'b0; hold = 1'b0; din = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Single word, then back-to-back words with din_valid held.
    send(8'hB4);
    wait_idle();
    send(8'hFF);
    send(8'h00);
    wait_idle();

    // Stall of three cycles right after bit 3 is presented.
    send(8'hB4);
    wait_shown(shown_cnt + 2);
    hold = 1'b1;
    repeat (3) tick();
    hold = 1'b0;
    wait_idle();

    // Reset while bit 5 of A5 is on the line, then a clean word.
    send(8'hA5);
    wait_shown(shown_cnt + 4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    send(8'h90);
    wait_idle();

    send(8'h01);
    send(8'h07);
    wait_idle();

    // Hold on the final bit of a word with the next word already offered.
    send(8'h3C);
    wait_shown(shown_cnt + 7);
    hold = 1'b1;
    din = 8'hC3;
    din_valid = 1'b1;
    repeat (2) tick();
    hold = 1'b0;
    send(8'hC3);
    wait_idle();

    // Random traffic with stalls and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (din_valid && xfer) din_valid = 1'b0;
      if (!din_valid && ($urandom % 3 != 0)) begin
        din = WIDTH'($urandom);
        din_valid = 1'b1;
      end
      hold = ($urandom % 5 == 0);
      rst  = ($urandom % 150 != 0);
    end
    tick();
    din_valid = 1'b0; hold = 1'b0; rst = 1'b1;
    wait_idle();
    check("queue_drained_msb", 32'(q_m.size()), 32'(0));
    check("queue_drained_lsb", 32'(q_l.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/moore_bit_serializer.md
MOORE_BIT_SERIALIZER -- requirements
Module: moore_bit_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data word width in bits, legal range 2..16.
REQ-002 SHALL provide parameter MSB_FIRST, default 1: 1 sends din[WIDTH-1] first; 0 sends din[0] first.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL provide port din, input, WIDTH bits: parallel word to serialize.
REQ-006 SHALL provide port din_valid, input, 1 bit: din holds a word offered for transfer.
REQ-007 SHALL provide port din_ready, output, 1 bit: block accepts din on this edge.
REQ-008 SHALL provide port hold, input, 1 bit: stall request from downstream.
REQ-009 SHALL provide port x, output, 1 bit: serial bit stream that feeds the downstream sequence detector.
REQ-010 SHALL provide port x_valid, output, 1 bit: x carries a live bit this cycle.
REQ-011 SHALL provide port busy, output, 1 bit: a word is in flight.

Function
REQ-012 SHALL transfer a word on any rising edge where din_valid=1 and din_ready=1, and SHALL ignore din at all other edges.
REQ-013 SHALL implement the states IDLE, SHIFT and PAR; PAR exists only per REQ-026.
REQ-014 SHALL move IDLE->SHIFT on a transfer, and SHALL stay in IDLE otherwise.
REQ-015 SHALL, in SHIFT with hold=0, present one bit per cycle for WIDTH cycles, tracked by a bit counter of ceil(log2(WIDTH)) bits.
REQ-016 SHALL register x, x_valid and busy; the word transferred at edge k SHALL appear on x during cycles k+1 .. k+WIDTH.
REQ-017 SHALL drive din_ready combinationally and SHALL assert it when rst=1 and either: state is IDLE; or hold=0 and the final bit (or the parity bit) is being presented.
REQ-018 SHALL, on a transfer at the final bit, re-enter SHIFT with the new word, so x_valid stays high continuously with zero gap.
REQ-019 SHALL, when the final bit completes without a transfer, return to IDLE with x_valid=0 and busy=0 on the next cycle.
REQ-020 SHALL, with hold=1, freeze the state, counter and shift register, hold x at its current value, drive x_valid=0 on the following cycle and drive din_ready=0.
REQ-021 SHALL resume from the same bit on the cycle after hold deasserts; no bit SHALL be lost or duplicated.
REQ-022 SHALL set busy=1 from the cycle after a transfer until the cycle after the last bit of the last word.
REQ-023 SHALL ignore din_valid=1 while din_ready=0; the upstream source holds din stable.

Reset
REQ-024 SHALL, on any rising edge with rst=0 (including mid-word), force state=IDLE, counter=0, shift register=0, x=0, x_valid=0 and busy=0, and SHALL discard the in-flight word.
REQ-025 SHALL hold din_ready=0 while rst=0; after reset, first transfer no earlier than the first edge with rst=1.

Configuration
REQ-026 SHALL, when macro SERIALIZER_PARITY_EN is defined, append one even-parity bit (XOR of all WIDTH bits) in state PAR after the final data bit; x_valid=1 during PAR; din_ready per REQ-017 is asserted in PAR instead of at the final data bit, and a word spans WIDTH+1 cycles.
REQ-027 SHALL, when SERIALIZER_PARITY_EN is undefined, contain no PAR state and no parity logic; a word spans exactly WIDTH cycles.

Verification
REQ-028 SHALL cover a single word: WIDTH=8, MSB_FIRST=1, din=8'hB4 -> x=1,0,1,1,0,1,0,0 on cycles k+1..k+8 with x_valid=1, then x_valid=0 and busy=0.
REQ-029 SHALL cover back-to-back words: 8'hFF then 8'h00 with din_valid held -> 16 contiguous x_valid=1 cycles, eight 1s then eight 0s.
REQ-030 SHALL cover a mid-word stall: 8'hB4, hold=1 for 3 cycles after bit 3 -> x_valid=0 for 3 cycles, x frozen, then bits 4..8 resume; the bit sequence is unchanged.
REQ-031 SHALL cover reset mid-word: rst=0 during bit 5 of 8'hA5 -> x=0, x_valid=0, busy=0 next edge; a new word 8'h90 afterwards emits cleanly as 1,0,0,1,0,0,0,0.
REQ-032 SHALL cover LSB-first order: MSB_FIRST=0, din=8'h01 -> x=1,0,0,0,0,0,0,0.
REQ-033 SHALL cover parity (SERIALIZER_PARITY_EN defined): din=8'hB4 -> ninth bit 0; din=8'h07 -> ninth bit 1; din_ready high only during the parity cycle.
